csi_capture_ctrl: RTL and testbench
===================================

Name: csi_capture_ctrl

Overview:
- Frame-capture sequencer between the CSI packet parser and the AXI-Stream output, running in the receive byte-clock domain.
- Gates the 64-bit pixel stream on frame boundaries only: arm, single-shot N frames or continuous, graceful stop, arm timeout.
- Counts frames and lines, and raises interrupt pulses for the control block to latch into its registers.

Parameters:
- FRAME_CNT_WIDTH, 16, width of frame target and frame counter.
- LINE_CNT_WIDTH, 16, width of line counters.
- TIMEOUT_WIDTH, 24, width of arm-timeout counter (byte-clock cycles).

Ports:
- rxbyteclkhs  in  1  receive byte clock; sole clock.
- rxbyteclkhs_reset  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse: arm a capture.
- cfg_stop  in  1  one-cycle pulse: stop after the current frame.
- cfg_continuous  in  1  1 = capture until stop; 0 = capture cfg_num_frames frames.
- cfg_num_frames  in  FRAME_CNT_WIDTH  frames per single-shot run; 0 is treated as 1.
- cfg_timeout  in  TIMEOUT_WIDTH  max cycles in ARMED; 0 disables the timeout.
- pkt_frame_start  in  1  frame-start short-packet pulse.
- pkt_frame_end  in  1  frame-end short-packet pulse.
- pkt_line_end  in  1  end-of-line pulse.
- s_axis_tvalid  in  1  parser data valid.
- s_axis_tdata  in  64  parser data.
- s_axis_tstrb  in  8  byte strobes.
- s_axis_tlast  in  1  end of line.
- s_axis_tready  out  1  ready to parser.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  64  output data.
- m_axis_tstrb  out  8  output strobes.
- m_axis_tlast  out  1  output end of line.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  state != IDLE.
- frame_irq  out  1  one-cycle pulse per captured frame end.
- done_irq  out  1  one-cycle pulse on return to IDLE after a capture run.
- timeout_irq  out  1  one-cycle pulse on arm timeout.
- frames_captured  out  FRAME_CNT_WIDTH  frames completed in the current or last run.
- lines_last_frame  out  LINE_CNT_WIDTH  line count latched at the last frame end.
- sync_errors  out  16  saturating count of frame start seen while in CAPTURE.

Behaviour:
- Reset (async): state IDLE; all counters 0; all irqs 0; busy 0.
- States: IDLE, ARMED, CAPTURE, STOPPING.
- IDLE:
  - cfg_start -> ARMED.
  - On entry to ARMED: clear frames_captured and the timeout counter.
- ARMED:
  - Timeout counter increments each cycle.
  - pkt_frame_start -> CAPTURE; line counter cleared.
  - cfg_timeout != 0 and counter == cfg_timeout-1 -> timeout_irq, IDLE; no done_irq.
  - cfg_stop -> IDLE with done_irq.
  - pkt_frame_end is ignored.
- CAPTURE:
  - pkt_line_end increments the line counter (saturating).
  - pkt_frame_end:
    - frames_captured+1 (saturating); lines_last_frame <= line count; frame_irq.
    - Next state is IDLE with done_irq if the run is finished (single-shot and new count >= max(cfg_num_frames,1)) or a stop is pending.
    - Otherwise next state is ARMED; the timeout counter is NOT re-cleared between frames of a run.
  - cfg_stop sets stop_pending, which is cleared on leaving CAPTURE.
  - pkt_frame_start (missing frame end): sync_errors+1; frame treated as restarted; line counter cleared; frames_captured unchanged.
- STOPPING: alias of CAPTURE with stop_pending = 1.
  - Entered when cfg_stop arrives in CAPTURE; exit rules are identical.
- cfg_start outside IDLE is ignored.
- Same-cycle cfg_stop and pkt_frame_end in CAPTURE: the frame completes and the run ends; this is the same result as a prior stop.
- Stream gating, combinational from the registered state:
  - CAPTURE/STOPPING: m_axis_* = s_axis_* and s_axis_tready = m_axis_tready.
  - Otherwise: m_axis_tvalid = 0 and s_axis_tready = 1, so beats are discarded.
- Beats coinciding with pkt_frame_start are discarded; beats coinciding with pkt_frame_end are forwarded (the state changes the next cycle).
- Zero added latency, no buffering; m_axis holds stable under backpressure because it mirrors the parser, which obeys AXI-S.
- Simultaneous pkt_frame_start and pkt_frame_end in CAPTURE: the frame end is processed first, then the frame start is applied (restart without sync error) when the run continues.
- Reset mid-frame: immediate IDLE; the stream drops to discard mode.

Test Plan:
1. Single-shot: num_frames=2, continuous=0; start; 2 frames of 4 lines × 3 beats -> 24 beats out, frame_irq ×2, done_irq once, frames_captured=2, lines_last_frame=4, busy falls the cycle after the 2nd frame end.
2. Pre-arm discard: 10 beats plus a full frame before start -> m_axis_tvalid stays 0, s_axis_tready=1 throughout, counters 0.
3. Stop mid-frame: continuous=1; stop during line 2 of frame 3 -> frame 3 completes all beats, frames_captured=3, done_irq, no 4th frame passed.
4. Timeout: cfg_timeout=100, no frame start -> timeout_irq exactly 100 cycles after ARMED entry, IDLE, done_irq=0; cfg_timeout=0 -> stays ARMED indefinitely.
5. Sync error: frame start, 2 lines, frame start again, 3 lines, frame end -> sync_errors=1, lines_last_frame=3, frames_captured=1.
6. Backpressure and reset: toggle m_axis_tready randomly during capture -> beat-exact match with input order; assert reset mid-frame -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/csi_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// csi_capture_ctrl_if
// AXI-Stream beat bundle used on both sides of the capture sequencer.
//   tvalid  data valid (source -> sink)
//   tdata   64-bit pixel payload
//   tstrb   byte strobes
//   tlast   end of line
//   tready  sink ready (sink -> source)
// master: the side that sources beats; slave: the side that sinks them.
// ---------------------------------------------------------------------------
interface csi_capture_ctrl_if;
  logic        tvalid;
  logic [63:0] tdata;
  logic [7:0]  tstrb;
  logic        tlast;
  logic        tready;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/csi_capture_ctrl.sv
// ---------------------------------------------------------------------------
// csi_capture_ctrl
// Frame-capture sequencer between the CSI packet parser and the AXI-Stream
// output, in the receive byte-clock domain. The pixel stream is passed
// through only while a frame is being captured; elsewhere beats are
// accepted and dropped. Capture runs are armed by software, end after N
// frames (single-shot) or on request (continuous), and can time out while
// waiting for a frame start.
//
// Ports
//   rxbyteclkhs        byte clock (sole clock)
//   rxbyteclkhs_reset  asynchronous active-high reset
//   cfg_start/stop     one-cycle control pulses
//   cfg_continuous     1 = run until stopped, 0 = cfg_num_frames frames
//   cfg_num_frames     frames per single-shot run (0 behaves as 1)
//   cfg_timeout        max cycles spent armed, 0 = no timeout
//   pkt_frame_start/frame_end/line_end  parser event pulses
//   s_axis             parser stream in (slave)
//   m_axis             gated stream out (master)
//   busy               sequencer not idle
//   frame_irq/done_irq/timeout_irq  one-cycle interrupt pulses
//   frames_captured    frames completed in the current or last run
//   lines_last_frame   line count latched at the last frame end
//   sync_errors        saturating count of unexpected frame starts
// ---------------------------------------------------------------------------
module csi_capture_ctrl #(
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int LINE_CNT_WIDTH  = 16,
  parameter int TIMEOUT_WIDTH   = 24
) (
  input  logic                       rxbyteclkhs,
  input  logic                       rxbyteclkhs_reset,
  input  logic                       cfg_start,
  input  logic                       cfg_stop,
  input  logic                       cfg_continuous,
  input  logic [FRAME_CNT_WIDTH-1:0] cfg_num_frames,
  input  logic [TIMEOUT_WIDTH-1:0]   cfg_timeout,
  input  logic                       pkt_frame_start,
  input  logic                       pkt_frame_end,
  input  logic                       pkt_line_end,
  csi_capture_ctrl_if.slave          s_axis,
  csi_capture_ctrl_if.master         m_axis,
  output logic                       busy,
  output logic                       frame_irq,
  output logic                       done_irq,
  output logic                       timeout_irq,
  output logic [FRAME_CNT_WIDTH-1:0] frames_captured,
  output logic [LINE_CNT_WIDTH-1:0]  lines_last_frame,
  output logic [15:0]                sync_errors
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_STOPPING
  } state_t;

  state_t                     state;
  logic [LINE_CNT_WIDTH-1:0]  line_cnt;
  logic [TIMEOUT_WIDTH-1:0]   tmo_cnt;

  function automatic logic [FRAME_CNT_WIDTH-1:0] sat_inc_frames(input logic [FRAME_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + FRAME_CNT_WIDTH'(1);
  endfunction

  function automatic logic [LINE_CNT_WIDTH-1:0] sat_inc_lines(input logic [LINE_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + LINE_CNT_WIDTH'(1);
  endfunction

  function automatic logic [15:0] sat_inc_sync(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [TIMEOUT_WIDTH-1:0] sat_inc_tmo(input logic [TIMEOUT_WIDTH-1:0] v);
    return (&v) ? v : v + TIMEOUT_WIDTH'(1);
  endfunction

  logic                       capturing;
  logic [FRAME_CNT_WIDTH-1:0] frames_next;
  logic [FRAME_CNT_WIDTH-1:0] frame_target;
  logic                       run_done;
  logic                       tmo_hit;

  assign capturing    = (state == ST_CAPTURE) || (state == ST_STOPPING);
  assign frames_next  = sat_inc_frames(frames_captured);
  assign frame_target = (cfg_num_frames == '0) ? FRAME_CNT_WIDTH'(1) : cfg_num_frames;
  // A stop arriving in the same cycle as the frame end counts as pending.
  assign run_done     = (!cfg_continuous && (frames_next >= frame_target)) ||
                        (state == ST_STOPPING) || cfg_stop;
  assign tmo_hit      = (cfg_timeout != '0) && (tmo_cnt == cfg_timeout - TIMEOUT_WIDTH'(1));

  assign busy = (state != ST_IDLE);

  // Zero-latency gate: outside a frame the parser is always accepted and its
  // beats are dropped, so it never stalls waiting for software to arm.
  assign m_axis.tvalid = capturing & s_axis.tvalid;
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tstrb  = s_axis.tstrb;
  assign m_axis.tlast  = s_axis.tlast;
  assign s_axis.tready = capturing ? m_axis.tready : 1'b1;

  always_ff @(posedge rxbyteclkhs or posedge rxbyteclkhs_reset) begin
    if (rxbyteclkhs_reset) begin
      state            <= ST_IDLE;
      line_cnt         <= '0;
      tmo_cnt          <= '0;
      frames_captured  <= '0;
      lines_last_frame <= '0;
      sync_errors      <= '0;
      frame_irq        <= 1'b0;
      done_irq         <= 1'b0;
      timeout_irq      <= 1'b0;
    end else begin
      frame_irq   <= 1'b0;
      done_irq    <= 1'b0;
      timeout_irq <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            state           <= ST_ARMED;
            frames_captured <= '0;
            tmo_cnt         <= '0;
          end
        end

        ST_ARMED: begin
          // The timeout budget spans the whole run, not each frame gap.
          tmo_cnt <= sat_inc_tmo(tmo_cnt);
          if (pkt_frame_start) begin
            state    <= ST_CAPTURE;
            line_cnt <= '0;
          end else if (tmo_hit) begin
            state       <= ST_IDLE;
            timeout_irq <= 1'b1;
          end else if (cfg_stop) begin
            state    <= ST_IDLE;
            done_irq <= 1'b1;
          end
        end

        ST_CAPTURE, ST_STOPPING: begin
          if (pkt_frame_end) begin
            frames_captured  <= frames_next;
            lines_last_frame <= pkt_line_end ? sat_inc_lines(line_cnt) : line_cnt;
            frame_irq        <= 1'b1;
            if (run_done) begin
              state    <= ST_IDLE;
              done_irq <= 1'b1;
            end else if (pkt_frame_start) begin
              // Back-to-back frame: the start belongs to the next frame.
              state    <= ST_CAPTURE;
              line_cnt <= '0;
            end else begin
              state <= ST_ARMED;
            end
          end else begin
            if (pkt_frame_start) begin
              // Missing frame end: restart the frame in place.
              sync_errors <= sat_inc_sync(sync_errors);
              line_cnt    <= '0;
            end else if (pkt_line_end) begin
              line_cnt <= sat_inc_lines(line_cnt);
            end
            if (cfg_stop) state <= ST_STOPPING;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi_capture_ctrl.sv
module tb_csi_capture_ctrl;
  localparam int FW = 16;
  localparam int LW = 16;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 0, cfg_stop = 0, cfg_continuous = 0;
  logic [FW-1:0] cfg_num_frames = '0;
  logic [TW-1:0] cfg_timeout = '0;
  logic          pkt_frame_start = 0, pkt_frame_end = 0, pkt_line_end = 0;
  logic          busy, frame_irq, done_irq, timeout_irq;
  logic [FW-1:0] frames_captured;
  logic [LW-1:0] lines_last_frame;
  logic [15:0]   sync_errors;

  csi_capture_ctrl_if s_if ();
  csi_capture_ctrl_if m_if ();

  always #5 clk = ~clk;

  csi_capture_ctrl #(.FRAME_CNT_WIDTH(FW), .LINE_CNT_WIDTH(LW), .TIMEOUT_WIDTH(TW)) dut (
    .rxbyteclkhs      (clk),
    .rxbyteclkhs_reset(rst),
    .cfg_start        (cfg_start),
    .cfg_stop         (cfg_stop),
    .cfg_continuous   (cfg_continuous),
    .cfg_num_frames   (cfg_num_frames),
    .cfg_timeout      (cfg_timeout),
    .pkt_frame_start  (pkt_frame_start),
    .pkt_frame_end    (pkt_frame_end),
    .pkt_line_end     (pkt_line_end),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .busy             (busy),
    .frame_irq        (frame_irq),
    .done_irq         (done_irq),
    .timeout_irq      (timeout_irq),
    .frames_captured  (frames_captured),
    .lines_last_frame (lines_last_frame),
    .sync_errors      (sync_errors)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame-level rules) ----------------
  typedef enum {M_IDLE, M_ARMED, M_CAP} mphase_t;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } beat_t;

  mphase_t m_phase = M_IDLE;
  bit      m_stop  = 0;
  int      m_frames = 0, m_lines = 0, m_last_lines = 0, m_sync = 0;
  int      exp_frame_irq = 0, exp_done_irq = 0, exp_tmo_irq = 0;
  int      obs_frame_irq = 0, obs_done_irq = 0, obs_tmo_irq = 0, obs_beats = 0;
  beat_t   exp_q[$];
  beat_t   mon_b;
  int      bp_mode = 0;  // 0: always ready, 1: random, 2: never ready

  task automatic model_event(input bit st, input bit sp, input bit fs, input bit fe, input bit le);
    int target;
    target = (cfg_num_frames == 0) ? 1 : int'(cfg_num_frames);
    if (st && m_phase == M_IDLE) begin
      m_phase  = M_ARMED;
      m_frames = 0;
    end
    if (sp) begin
      if (m_phase == M_ARMED) begin
        m_phase = M_IDLE;
        exp_done_irq++;
      end else if (m_phase == M_CAP) begin
        m_stop = 1;
      end
    end
    if (fe && m_phase == M_CAP) begin
      if (le) m_lines++;
      m_frames++;
      m_last_lines = m_lines;
      exp_frame_irq++;
      if ((!cfg_continuous && m_frames >= target) || m_stop) begin
        m_phase = M_IDLE;
        m_stop  = 0;
        exp_done_irq++;
      end else begin
        m_phase = M_ARMED;
      end
      le = 0;
    end
    if (fs) begin
      if (m_phase == M_ARMED) begin
        m_phase = M_CAP;
        m_lines = 0;
      end else if (m_phase == M_CAP) begin
        m_sync++;
        m_lines = 0;
        le = 0;
      end
    end
    if (le && m_phase == M_CAP) m_lines++;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (m_if.tvalid && m_if.tready) begin
        obs_beats++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: actual data %h, required no beat", m_if.tdata);
        end else begin
          mon_b = exp_q.pop_front();
          check("beat_data", m_if.tdata, mon_b.d);
          check("beat_strb", 64'(m_if.tstrb), 64'(mon_b.s));
          check("beat_last", 64'(m_if.tlast), 64'(mon_b.l));
        end
      end
      if (frame_irq)   obs_frame_irq++;
      if (done_irq)    obs_done_irq++;
      if (timeout_irq) obs_tmo_irq++;
    end
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1:       m_if.tready = 1'($urandom_range(0, 1));
        2:       m_if.tready = 1'b0;
        default: m_if.tready = 1'b1;
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input bit st, input bit sp, input bit fs, input bit fe, input bit le);
    cfg_start = st; cfg_stop = sp; pkt_frame_start = fs; pkt_frame_end = fe; pkt_line_end = le;
    tick();
    cfg_start = 0; cfg_stop = 0; pkt_frame_start = 0; pkt_frame_end = 0; pkt_line_end = 0;
    model_event(st, sp, fs, fe, le);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    bit hs;
    bit first;
    int cyc;
    if (m_phase == M_CAP) exp_q.push_back('{d: d, s: s, l: l});
    s_if.tvalid = 1; s_if.tdata = d; s_if.tstrb = s; s_if.tlast = l;
    hs = 0; first = 1; cyc = 0;
    do begin
      @(negedge clk);
      if (first && m_phase != M_CAP) begin
        check("discard_tready", 64'(s_if.tready), 64'd1);
        check("discard_tvalid", 64'(m_if.tvalid), 64'd0);
      end
      first = 0;
      hs = s_if.tvalid && s_if.tready;
      tick();
      cyc++;
    end while (!hs && cyc < 200);
    if (!hs) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_stall: actual no handshake in %0d cycles, required handshake", cyc);
    end
    s_if.tvalid = 0;
  endtask

  task automatic send_line(input int nb, input bit stop_mid);
    for (int b = 0; b < nb; b++) begin
      send_beat({$urandom, $urandom}, 8'($urandom), b == nb - 1);
      if (stop_mid && b == 0) pulses(0, 1, 0, 0, 0);
    end
    pulses(0, 0, 0, 0, 1);
  endtask

  task automatic send_frame(input int nl, input int nb, input int stop_line);
    pulses(0, 0, 1, 0, 0);
    for (int l = 0; l < nl; l++) send_line(nb, l == stop_line);
    pulses(0, 0, 0, 1, 0);
  endtask

  task automatic end_checks(input string tag);
    tick();
    tick();
    $display("scenario %s", tag);
    check("frames_captured", 64'(frames_captured), 64'(m_frames));
    check("lines_last_frame", 64'(lines_last_frame), 64'(m_last_lines));
    check("sync_errors", 64'(sync_errors), 64'(m_sync));
    check("busy", 64'(busy), 64'(m_phase != M_IDLE));
    check("frame_irq_count", 64'(obs_frame_irq), 64'(exp_frame_irq));
    check("done_irq_count", 64'(obs_done_irq), 64'(exp_done_irq));
    check("timeout_irq_count", 64'(obs_tmo_irq), 64'(exp_tmo_irq));
    check("pending_beats", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_irqs"}, 64'({frame_irq, done_irq, timeout_irq}), 64'd0);
    check({tag, "_frames"}, 64'(frames_captured), 64'd0);
    check({tag, "_lines"}, 64'(lines_last_frame), 64'd0);
    check({tag, "_sync"}, 64'(sync_errors), 64'd0);
    check({tag, "_m_tvalid"}, 64'(m_if.tvalid), 64'd0);
    check({tag, "_s_tready"}, 64'(s_if.tready), 64'd1);
  endtask

  initial begin
    int beats0;
    int k_irq;
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tstrb = '0; s_if.tlast = 0;

    // Reset state
    #2;
    check_reset_outputs("reset");
    tick();
    tick();
    rst = 0;
    tick();

    // Pre-arm discard: loose beats plus a whole frame
    for (int i = 0; i < 10; i++) send_beat({$urandom, $urandom}, 8'($urandom), 1'(i == 9));
    send_frame(2, 2, -1);
    check("prearm_beats_out", 64'(obs_beats), 64'd0);
    end_checks("prearm");

    // Single-shot, two frames of 4 lines x 3 beats
    cfg_continuous = 0; cfg_num_frames = 16'd2; cfg_timeout = '0;
    beats0 = obs_beats;
    pulses(1, 0, 0, 0, 0);
    send_frame(4, 3, -1);
    check("busy_between_frames", 64'(busy), 64'd1);
    pulses(0, 0, 1, 0, 0);
    for (int l = 0; l < 4; l++) send_line(3, 0);
    pulses(0, 0, 0, 1, 0);
    check("busy_after_last_end", 64'(busy), 64'd0);
    end_checks("single_shot");
    check("single_shot_beats", 64'(obs_beats - beats0), 64'd24);
    check("single_shot_frames", 64'(frames_captured), 64'd2);

    // Continuous, stop during line 2 of frame 3, frame 4 must be dropped
    cfg_continuous = 1;
    beats0 = obs_beats;
    pulses(1, 0, 0, 0, 0);
    send_frame(4, 3, -1);
    send_frame(4, 3, -1);
    send_frame(4, 3, 1);
    send_frame(4, 3, -1);
    end_checks("stop_mid_frame");
    check("stop_frames", 64'(frames_captured), 64'd3);
    check("stop_beats", 64'(obs_beats - beats0), 64'd36);

    // Arm timeout
    cfg_continuous = 0; cfg_num_frames = 16'd1; cfg_timeout = 24'd100;
    pulses(1, 0, 0, 0, 0);
    k_irq = -1;
    for (int k = 1; k <= 150 && k_irq < 0; k++) begin
      tick();
      if (timeout_irq) k_irq = k;
    end
    check("timeout_latency", 64'(k_irq), 64'd100);
    check("timeout_busy", 64'(busy), 64'd0);
    m_phase = M_IDLE;
    exp_tmo_irq++;
    end_checks("timeout");

    cfg_timeout = '0;
    pulses(1, 0, 0, 0, 0);
    repeat (300) tick();
    check("no_timeout_busy", 64'(busy), 64'd1);
    pulses(0, 1, 0, 0, 0);
    end_checks("timeout_disabled");

    // Sync error, with num_frames = 0 behaving as one frame
    cfg_continuous = 0; cfg_num_frames = '0;
    pulses(1, 0, 0, 0, 0);
    pulses(0, 0, 1, 0, 0);
    for (int l = 0; l < 2; l++) send_line(2, 0);
    pulses(0, 0, 1, 0, 0);
    for (int l = 0; l < 3; l++) send_line(2, 0);
    pulses(0, 0, 0, 1, 0);
    end_checks("sync_error");
    check("sync_errors_one", 64'(sync_errors), 64'd1);
    check("sync_lines", 64'(lines_last_frame), 64'd3);

    // Random backpressure, back-to-back frame end + start, stop
    bp_mode = 1;
    cfg_continuous = 1;
    pulses(1, 0, 0, 0, 0);
    send_frame($urandom_range(1, 4), $urandom_range(1, 4), -1);
    pulses(0, 0, 1, 0, 0);
    for (int l = 0; l < 3; l++) send_line($urandom_range(1, 4), 0);
    pulses(0, 0, 1, 1, 0);
    for (int l = 0; l < 2; l++) send_line($urandom_range(1, 4), l == 1);
    pulses(0, 0, 0, 1, 0);
    end_checks("backpressure");

    // Reset mid-frame
    pulses(1, 0, 0, 0, 0);
    pulses(0, 0, 1, 0, 0);
    send_line(2, 0);
    bp_mode = 2;
    tick();
    tick();
    s_if.tvalid = 1; s_if.tdata = 64'hDEAD_BEEF_0123_4567;
    #3;
    rst = 1;
    #1;
    check_reset_outputs("midframe_reset");
    s_if.tvalid = 0;
    m_phase = M_IDLE; m_stop = 0; m_frames = 0; m_last_lines = 0; m_sync = 0; m_lines = 0;
    tick();
    rst = 0;
    bp_mode = 1;
    end_checks("after_reset");

    // Stop in the same cycle as frame end
    cfg_continuous = 1;
    pulses(1, 0, 0, 0, 0);
    pulses(0, 0, 1, 0, 0);
    send_line(3, 0);
    pulses(0, 1, 0, 1, 0);
    end_checks("stop_with_frame_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
